// File: rtl/sdp_prelu_pkg.sv
// ---------------------------------------------------------------------------
// sdp_prelu_pkg : shared state encoding, default widths and result-width check
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sdp_prelu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_IN_WIDTH  = 32;
  localparam int DEF_OP_WIDTH  = 32;
  localparam int DEF_OUT_WIDTH = 64;
  localparam int DEF_CH_NUM    = 16;
  localparam int DEF_CH_AW     = 4;
  localparam int DEF_CNT_W     = 13;

  // The product must fit the result word without truncation.
  function automatic bit out_width_ok(int out_w, int in_w, int op_w);
    return out_w >= (in_w + op_w);
  endfunction

  localparam bit DEF_RESULT_W_OK = out_width_ok(DEF_OUT_WIDTH, DEF_IN_WIDTH, DEF_OP_WIDTH);

endpackage

`default_nettype wire

// File: rtl/sdp_prelu_ctrl_if.sv
// ---------------------------------------------------------------------------
// sdp_prelu_ctrl_if : config, launch, alpha-write and stream bundle
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sdp_prelu_ctrl_if
  import sdp_prelu_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OP_WIDTH  = DEF_OP_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int CH_AW     = DEF_CH_AW,
  parameter int CNT_W     = DEF_CNT_W
);

  logic                 cfg_prelu_en;
  logic [CNT_W-1:0]     cfg_width;
  logic [CH_AW-1:0]     cfg_channel;
  logic                 op_wr_en;
  logic [CH_AW-1:0]     op_wr_addr;
  logic [OP_WIDTH-1:0]  op_wr_data;
  logic                 op_start;
  logic                 op_busy;
  logic                 op_done;
  logic                 in_pvld;
  logic                 in_prdy;
  logic [IN_WIDTH-1:0]  in_pd;
  logic                 out_pvld;
  logic                 out_prdy;
  logic [OUT_WIDTH-1:0] out_pd;

  modport slave (
    input  cfg_prelu_en, cfg_width, cfg_channel,
    input  op_wr_en, op_wr_addr, op_wr_data, op_start,
    output op_busy, op_done,
    input  in_pvld, in_pd,
    output in_prdy,
    output out_pvld, out_pd,
    input  out_prdy
  );

  modport master (
    output cfg_prelu_en, cfg_width, cfg_channel,
    output op_wr_en, op_wr_addr, op_wr_data, op_start,
    input  op_busy, op_done,
    output in_pvld, in_pd,
    input  in_prdy,
    input  out_pvld, out_pd,
    output out_prdy
  );

endinterface

`default_nettype wire

// File: rtl/sdp_prelu_alpha_rf.sv
// ---------------------------------------------------------------------------
// sdp_prelu_alpha_rf : per-channel alpha flop array, sync write / comb read
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sdp_prelu_alpha_rf
  import sdp_prelu_pkg::*;
#(
  parameter int CH_NUM   = DEF_CH_NUM,
  parameter int CH_AW    = DEF_CH_AW,
  parameter int OP_WIDTH = DEF_OP_WIDTH
) (
  input  wire logic                clk_i,
  input  wire logic                wr_en_i,
  input  wire logic [CH_AW-1:0]    wr_addr_i,
  input  wire logic [OP_WIDTH-1:0] wr_data_i,
  input  wire logic [CH_AW-1:0]    rd_addr_i,
  output      logic [OP_WIDTH-1:0] rd_data_o
);

  // Contents are deliberately left unreset; software loads them before a pass.
  logic [OP_WIDTH-1:0] mem_q [CH_NUM];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/sdp_prelu_ctrl.sv
// ---------------------------------------------------------------------------
// sdp_prelu_ctrl : per-channel PReLU sequencer with registered output stage
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sdp_prelu_ctrl
  import sdp_prelu_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OP_WIDTH  = DEF_OP_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int CH_NUM    = DEF_CH_NUM,
  parameter int CH_AW     = DEF_CH_AW,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  wire logic          autosa_core_clk,
  input  wire logic          autosa_core_rst,
  sdp_prelu_ctrl_if.slave    bus
);

  if (!out_width_ok(OUT_WIDTH, IN_WIDTH, OP_WIDTH)) begin : g_width_check
    $error("sdp_prelu_ctrl: OUT_WIDTH smaller than IN_WIDTH+OP_WIDTH");
  end

  state_e                 state_q;
  logic                   prelu_en_q;
  logic [CNT_W-1:0]       width_q;
  logic [CH_AW-1:0]       channel_q;
  logic [CNT_W-1:0]       elem_cnt_q;
  logic [CH_AW-1:0]       ch_cnt_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   out_pvld_q;
  logic [OUT_WIDTH-1:0]   out_pd_q;

  logic                   in_prdy_d;
  logic                   accept_d;
  logic                   elem_wrap_d;
  logic                   last_elem_d;
  logic                   alpha_wr_d;
  logic [OP_WIDTH-1:0]    alpha_rd_d;
  logic signed [IN_WIDTH+OP_WIDTH-1:0] prod_d;
  logic [OUT_WIDTH-1:0]   result_d;

  assign in_prdy_d   = (state_q == ST_RUN) && (!out_pvld_q || bus.out_prdy);
  assign accept_d    = bus.in_pvld && in_prdy_d;
  assign elem_wrap_d = (elem_cnt_q == width_q);
  assign last_elem_d = elem_wrap_d && (ch_cnt_q == channel_q);
  assign alpha_wr_d  = bus.op_wr_en && (state_q == ST_IDLE);

  sdp_prelu_alpha_rf #(
    .CH_NUM   (CH_NUM),
    .CH_AW    (CH_AW),
    .OP_WIDTH (OP_WIDTH)
  ) u_alpha_rf (
    .clk_i     (autosa_core_clk),
    .wr_en_i   (alpha_wr_d),
    .wr_addr_i (bus.op_wr_addr),
    .wr_data_i (bus.op_wr_data),
    .rd_addr_i (ch_cnt_q),
    .rd_data_o (alpha_rd_d)
  );

  // Non-negative inputs bypass the multiplier only when PReLU mode is on.
  always_comb begin
    prod_d   = $signed(bus.in_pd) * $signed(alpha_rd_d);
    result_d = OUT_WIDTH'(bus.in_pd);
    if (!(prelu_en_q && !bus.in_pd[IN_WIDTH-1])) begin
      result_d = OUT_WIDTH'(prod_d);
    end
  end

  always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
    if (autosa_core_rst) begin
      state_q    <= ST_IDLE;
      prelu_en_q <= 1'b0;
      width_q    <= '0;
      channel_q  <= '0;
      elem_cnt_q <= '0;
      ch_cnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_pvld_q <= 1'b0;
      out_pd_q   <= '0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.op_start) begin
            prelu_en_q <= bus.cfg_prelu_en;
            width_q    <= bus.cfg_width;
            channel_q  <= bus.cfg_channel;
            elem_cnt_q <= '0;
            ch_cnt_q   <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept_d) begin
            if (elem_wrap_d) begin
              elem_cnt_q <= '0;
              ch_cnt_q   <= last_elem_d ? '0 : ch_cnt_q + 1'b1;
            end else begin
              elem_cnt_q <= elem_cnt_q + 1'b1;
            end
            if (last_elem_d) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Finish only once the last result has left the output register.
          if (!out_pvld_q || bus.out_prdy) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase

      if (accept_d) begin
        out_pvld_q <= 1'b1;
        out_pd_q   <= result_d;
      end else if (bus.out_prdy) begin
        out_pvld_q <= 1'b0;
      end
    end
  end

  assign bus.in_prdy  = in_prdy_d;
  assign bus.op_busy  = busy_q;
  assign bus.op_done  = done_q;
  assign bus.out_pvld = out_pvld_q;
  assign bus.out_pd   = out_pd_q;

endmodule

`default_nettype wire

// File: tb/tb_sdp_prelu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdp_prelu_ctrl : scenario tasks checked against a per-element PReLU model
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sdp_prelu_ctrl;

  localparam int IN_W  = 32;
  localparam int OP_W  = 32;
  localparam int OUT_W = 64;
  localparam int CHN   = 16;
  localparam int AW    = 4;
  localparam int CW    = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdp_prelu_ctrl_if #(.IN_WIDTH(IN_W), .OP_WIDTH(OP_W), .OUT_WIDTH(OUT_W),
                      .CH_AW(AW), .CNT_W(CW)) bus ();

  sdp_prelu_ctrl #(.IN_WIDTH(IN_W), .OP_WIDTH(OP_W), .OUT_WIDTH(OUT_W),
                   .CH_NUM(CHN), .CH_AW(AW), .CNT_W(CW)) dut (
    .autosa_core_clk (clk),
    .autosa_core_rst (rst),
    .bus             (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          model_alpha [CHN];
  int          stim_q [$];
  logic [63:0] got_q [$];
  int          done_cnt;
  int          done_busy_err;
  int          prdy_mode;

  // 0: always ready, 1: random ready, 2: held low
  initial forever begin
    @(posedge clk);
    #1;
    case (prdy_mode)
      0:       bus.out_prdy = 1'b1;
      1:       bus.out_prdy = ($urandom_range(0, 3) != 0);
      default: bus.out_prdy = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && bus.out_pvld && bus.out_prdy) got_q.push_back(bus.out_pd);
    if (bus.op_done) begin
      done_cnt++;
      if (bus.op_busy || bus.out_pvld) done_busy_err++;
    end
  end

  function automatic logic [63:0] model_out(int x, int a, bit prelu);
    if (prelu && x >= 0) return {32'd0, x};
    return 64'(longint'(x) * longint'(a));
  endfunction

  task automatic clk_step;
    @(posedge clk);
    #1;
  endtask

  task automatic write_alpha(int addr, int val);
    bus.op_wr_en   = 1'b1;
    bus.op_wr_addr = addr[AW-1:0];
    bus.op_wr_data = val;
    clk_step();
    bus.op_wr_en   = 1'b0;
    model_alpha[addr] = val;
  endtask

  function automatic int rand_elem();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return 32'sh8000_0000;
    if (r == 2) return 32'sh7fff_ffff;
    if (r < 6)  return -int'($urandom_range(1, 1000));
    return int'($urandom());
  endfunction

  task automatic do_pass(string name, bit prelu, int w, int c, int base_mode, bit gaps,
                         int stall_at, int wr_at, int start_at);
    logic [63:0] exp_q [$];
    logic [63:0] hold;
    int n;
    bit acc;
    n = (w + 1) * (c + 1);
    for (int i = 0; i < n; i++) exp_q.push_back(model_out(stim_q[i], model_alpha[i / (w + 1)], prelu));
    got_q.delete();
    done_cnt = 0;
    done_busy_err = 0;
    prdy_mode = base_mode;
    bus.cfg_prelu_en = prelu;
    bus.cfg_width    = w[CW-1:0];
    bus.cfg_channel  = c[AW-1:0];
    bus.op_start     = 1'b1;
    clk_step();
    bus.op_start     = 1'b0;
    total++;
    if (bus.op_busy !== 1'b1) begin
      bad++; $display("FAIL %s busy_after_start: got %b expected 1", name, bus.op_busy);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) clk_step();
      bus.in_pvld = 1'b1;
      bus.in_pd   = stim_q[i];
      if (i == wr_at) begin
        bus.op_wr_en   = 1'b1;
        bus.op_wr_addr = AW'(i / (w + 1));
        bus.op_wr_data = 32'h7fff_0001;
      end
      if (i == start_at) begin
        bus.op_start     = 1'b1;
        bus.cfg_prelu_en = !prelu;
        bus.cfg_width    = CW'(w + 1);
        bus.cfg_channel  = AW'(c + 1);
      end
      if (i == stall_at) begin
        prdy_mode    = 2;
        bus.out_prdy = 1'b0;
        @(negedge clk);
        hold = bus.out_pd;
        total++;
        if (bus.out_pvld !== 1'b1) begin
          bad++; $display("FAIL %s stall_pvld: got %b expected 1", name, bus.out_pvld);
        end
        repeat (5) begin
          @(negedge clk);
          total++;
          if (bus.in_prdy !== 1'b0 || bus.out_pd !== hold) begin
            bad++;
            $display("FAIL %s stall_hold: in_prdy=%b out_pd=%h expected in_prdy=0 out_pd=%h",
                     name, bus.in_prdy, bus.out_pd, hold);
          end
        end
        @(posedge clk);
        #1;
        prdy_mode    = base_mode;
        bus.out_prdy = 1'b1;
      end
      acc = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        acc = bus.in_prdy;
        @(posedge clk);
        #1;
        if (acc) break;
      end
      bus.in_pvld  = 1'b0;
      bus.op_wr_en = 1'b0;
      bus.op_start = 1'b0;
      if (!acc) begin
        total++; bad++;
        $display("FAIL %s accept_timeout: element %0d not accepted, expected accept", name, i);
        return;
      end
    end
    for (int k = 0; k < 100 && done_cnt == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    total++;
    if (done_cnt !== 1) begin
      bad++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    total++;
    if (done_busy_err !== 0 || bus.op_busy !== 1'b0) begin
      bad++; $display("FAIL %s busy_drop: busy=%b err=%0d expected busy=0 err=0", name, bus.op_busy, done_busy_err);
    end
    total++;
    if (got_q.size() !== n) begin
      bad++; $display("FAIL %s result_count: got %0d expected %0d", name, got_q.size(), n);
    end
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL %s result[%0d]: got %h expected %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset;
    bus.cfg_prelu_en = 0; bus.cfg_width = '0; bus.cfg_channel = '0;
    bus.op_wr_en = 0; bus.op_wr_addr = '0; bus.op_wr_data = '0; bus.op_start = 0;
    bus.in_pvld = 0; bus.in_pd = '0; bus.out_prdy = 1;
    rst = 1'b1;
    repeat (3) clk_step();
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.op_busy  !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.op_busy); end
    total++; if (bus.op_done  !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", bus.op_done); end
    total++; if (bus.in_prdy  !== 1'b0) begin bad++; $display("FAIL reset_in_prdy: got %b expected 0", bus.in_prdy); end
    total++; if (bus.out_pvld !== 1'b0) begin bad++; $display("FAIL reset_out_pvld: got %b expected 0", bus.out_pvld); end
    total++; if (bus.out_pd   !== 64'd0) begin bad++; $display("FAIL reset_out_pd: got %h expected 0", bus.out_pd); end
    clk_step();
  endtask

  task automatic test_prelu_mixed;
    logic [63:0] req [4];
    req[0] = 64'd5; req[1] = 64'hFFFF_FFFF_FFFF_FFFA; req[2] = 64'd4; req[3] = 64'd7;
    write_alpha(0, 2);
    write_alpha(1, -1);
    stim_q = '{5, -3, -4, 7};
    do_pass("prelu_mixed", 1'b1, 1, 1, 0, 1'b0, -1, -1, -1);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== req[i]) begin
        bad++; $display("FAIL prelu_mixed_table[%0d]: got %h expected %h", i, got_q[i], req[i]);
      end
    end
  endtask

  task automatic test_prelu_off;
    stim_q = '{5, -3, -4, 7};
    do_pass("prelu_off", 1'b0, 1, 1, 0, 1'b0, -1, -1, -1);
    total++;
    if (got_q.size() == 0 || got_q[0] !== 64'd10) begin
      bad++; $display("FAIL prelu_off_first: got %h expected %h", (got_q.size() > 0) ? got_q[0] : 64'hx, 64'd10);
    end
  endtask

  task automatic test_backpressure;
    write_alpha(0, 3);
    write_alpha(1, -7);
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(rand_elem());
    do_pass("backpressure", 1'b1, 3, 1, 0, 1'b0, 3, -1, -1);
  endtask

  task automatic test_alpha_write_busy;
    write_alpha(0, -5);
    write_alpha(1, 9);
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(-int'($urandom_range(1, 5000)));
    do_pass("alpha_write_busy", 1'b1, 2, 1, 0, 1'b0, -1, 1, -1);
  endtask

  task automatic test_launch_guard;
    write_alpha(2, 11);
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(rand_elem());
    do_pass("launch_guard", 1'b1, 1, 2, 1, 1'b0, -1, -1, 2);
  endtask

  task automatic test_reset_mid_pass;
    bit acc;
    got_q.delete();
    done_cnt  = 0;
    prdy_mode = 0;
    bus.cfg_prelu_en = 1'b1; bus.cfg_width = CW'(1); bus.cfg_channel = AW'(1);
    bus.op_start = 1'b1;
    clk_step();
    bus.op_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_pvld = 1'b1;
      bus.in_pd   = -int'(i + 2);
      acc = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        acc = bus.in_prdy;
        @(posedge clk);
        #1;
        if (acc) break;
      end
      bus.in_pvld = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.out_pvld !== 1'b0) begin bad++; $display("FAIL midreset_out_pvld: got %b expected 0", bus.out_pvld); end
    total++; if (bus.op_busy  !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b expected 0", bus.op_busy); end
    total++; if (bus.in_prdy  !== 1'b0) begin bad++; $display("FAIL midreset_in_prdy: got %b expected 0", bus.in_prdy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d expected 0", done_cnt); end
    clk_step();
    stim_q.delete();
    for (int i = 0; i < 4; i++) stim_q.push_back(rand_elem());
    do_pass("relaunch", 1'b1, 1, 1, 0, 1'b0, -1, -1, -1);
  endtask

  task automatic test_random;
    int w, c;
    bit pr;
    for (int p = 0; p < 7; p++) begin
      if (p == 0)      begin w = 0; c = 0;  end
      else if (p == 1) begin w = 0; c = 15; end
      else begin w = $urandom_range(0, 3); c = $urandom_range(0, 15); end
      pr = $urandom_range(0, 1);
      for (int ch = 0; ch <= c; ch++) write_alpha(ch, int'($urandom()));
      stim_q.delete();
      for (int i = 0; i < (w + 1) * (c + 1); i++) stim_q.push_back(rand_elem());
      do_pass($sformatf("random_pass%0d", p), pr, w, c, (p < 2) ? 0 : 1, (p >= 2), -1, -1, -1);
    end
  endtask

  initial begin
    prdy_mode = 0;
    done_cnt  = 0;
    done_busy_err = 0;
    test_reset();
    test_prelu_mixed();
    test_prelu_off();
    test_backpressure();
    test_alpha_write_busy();
    test_launch_guard();
    test_reset_mid_pass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
